range_filter: RTL and testbench

Downstream consumer of the HC-SR04 driver's `len`/`done` pair. Detects each completed echo measurement and optionally rejects implausible samples. Keeps a sliding window of the last 2^WIN_LOG2 accepted echo widths in a ring buffer with a running sum. Converts the window average from microseconds to centimetres and presents it with a one-cycle valid strobe to the scan/report logic.

---
 rtl/udar_pkg.sv | 13 +
 rtl/range_ring.sv | 33 +++
 rtl/range_filter.sv | 133 +++++++++++++
 tb/tb_range_filter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/udar_pkg.sv
// Shared constants for the ultrasonic ranging blocks: us->cm scaling and
// range_filter FSM state encoding.
package udar_pkg;

  localparam int US_TO_CM_MUL   = 1130;
  localparam int US_TO_CM_SHIFT = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_CONV   = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

endpackage

// File: rtl/range_ring.sv
// Ring buffer of accepted echo widths: combinational read of the slot about to
// be overwritten (the oldest entry), synchronous write with wrapping pointer.
module range_ring
  import udar_pkg::*;
#(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] oldest_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [DEPTH_LOG2-1:0]   wptr_q;

  assign oldest_o = mem_q[wptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
    end else if (we_i) begin
      mem_q[wptr_q] <= wdata_i;
      wptr_q        <= wptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/range_filter.sv
// Sliding-window average of HC-SR04 echo widths, converted to centimetres.
// Define RANGE_OUTLIER_REJECT_EN to discard zero or > MAX_US samples.
module range_filter
  import udar_pkg::*;
#(
  parameter int CAP_LEN  = 16,
  parameter int WIN_LOG2 = 2,
  parameter int CM_LEN   = 10,
  parameter int MAX_US   = 23200
) (
  input  logic               clk50M,
  input  logic               rst_n,
  input  logic [CAP_LEN-1:0] sample_len,
  input  logic               sample_done,
  output logic [CM_LEN-1:0]  dist_cm,
  output logic               dist_valid,
  output logic               full,
  output logic               rejected
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SW    = CAP_LEN + WIN_LOG2;
  localparam int PW    = CAP_LEN + 11;
  localparam logic [CAP_LEN-1:0]  MAX_LIM  = CAP_LEN'(MAX_US);
  localparam logic [WIN_LOG2:0]   FILL_MAX = (WIN_LOG2+1)'(DEPTH);
`ifdef RANGE_OUTLIER_REJECT_EN
  localparam bit REJECT_EN = 1'b1;
`else
  localparam bit REJECT_EN = 1'b0;
`endif

  logic [1:0]         state_q, state_d;
  logic               done_prev_q;
  logic [CAP_LEN-1:0] cur_q, cur_d;
  logic [SW-1:0]      sum_q, sum_d;
  logic [WIN_LOG2:0]  fill_q, fill_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [CM_LEN-1:0]  dist_cm_q, dist_cm_d;
  logic               dist_valid_q, dist_valid_d;
  logic               full_q, full_d;
  logic               rejected_q, rejected_d;

  logic [CAP_LEN-1:0] oldest;
  logic               outlier, ring_we, rise;
  logic [PW-1:0]      cm_full;

  assign rise    = sample_done && !done_prev_q;
  assign outlier = REJECT_EN && ((cur_q == '0) || (cur_q > MAX_LIM));
  assign ring_we = (state_q == ST_ACCEPT) && !outlier;
  assign cm_full = prod_q >> US_TO_CM_SHIFT;

  range_ring #(.W(CAP_LEN), .DEPTH_LOG2(WIN_LOG2)) u_ring (
    .clk_i    (clk50M),
    .rst_ni   (rst_n),
    .we_i     (ring_we),
    .wdata_i  (cur_q),
    .oldest_o (oldest)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    sum_d        = sum_q;
    fill_d       = fill_q;
    prod_d       = prod_q;
    dist_cm_d    = dist_cm_q;
    dist_valid_d = 1'b0;
    full_d       = full_q;
    rejected_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cur_d   = sample_len;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (outlier) begin
          rejected_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          // sum never goes negative: oldest is always a term already in sum
          sum_d   = sum_q + SW'(cur_q) - SW'(oldest);
          fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
          full_d  = full_q || (fill_d == FILL_MAX);
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        prod_d  = PW'(sum_q >> WIN_LOG2) * PW'(US_TO_CM_MUL);
        state_d = ST_OUT;
      end
      default: begin
        dist_cm_d    = (cm_full > PW'((1 << CM_LEN) - 1)) ? '1 : cm_full[CM_LEN-1:0];
        dist_valid_d = full_q;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // done_prev resets high so a done level held through reset is not a new sample
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      done_prev_q  <= 1'b1;
      cur_q        <= '0;
      sum_q        <= '0;
      fill_q       <= '0;
      prod_q       <= '0;
      dist_cm_q    <= '0;
      dist_valid_q <= 1'b0;
      full_q       <= 1'b0;
      rejected_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_prev_q  <= sample_done;
      cur_q        <= cur_d;
      sum_q        <= sum_d;
      fill_q       <= fill_d;
      prod_q       <= prod_d;
      dist_cm_q    <= dist_cm_d;
      dist_valid_q <= dist_valid_d;
      full_q       <= full_d;
      rejected_q   <= rejected_d;
    end
  end

  assign dist_cm    = dist_cm_q;
  assign dist_valid = dist_valid_q;
  assign full       = full_q;
  assign rejected   = rejected_q;

endmodule

// File: tb/tb_range_filter.sv
// Scoreboard bench for range_filter: a behavioural window model pushes the
// expected result of each sample; it is popped and compared at OUT time.
module tb_range_filter;

  localparam int CAP_LEN = 16;
  localparam int CM_LEN  = 10;
  localparam int MAX_US  = 23200;

  logic               clk50M = 1'b0;
  logic               rst_n  = 1'b0;
  logic [CAP_LEN-1:0] sample_len = '0;
  logic               sample_done = 1'b0;
  logic [CM_LEN-1:0]  dist_cm;
  logic               dist_valid, full, rejected;

  range_filter #(.CAP_LEN(CAP_LEN), .WIN_LOG2(2), .CM_LEN(CM_LEN), .MAX_US(MAX_US)) dut (
    .clk50M      (clk50M),
    .rst_n       (rst_n),
    .sample_len  (sample_len),
    .sample_done (sample_done),
    .dist_cm     (dist_cm),
    .dist_valid  (dist_valid),
    .full        (full),
    .rejected    (rejected)
  );

  always #10 clk50M = ~clk50M;

  typedef struct {
    bit rej;
    bit valid;
    int cm;
    bit full;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  int m_ring[4];
  int m_wptr, m_sum, m_fill, m_cm;
  bit m_full;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ring[i] = 0;
    m_wptr = 0; m_sum = 0; m_fill = 0; m_cm = 0; m_full = 0;
  endtask

  task automatic model_push(input int len);
    exp_t e;
    bit out;
    int avg;
`ifdef RANGE_OUTLIER_REJECT_EN
    out = (len == 0) || (len > MAX_US);
`else
    out = 1'b0;
`endif
    if (out) begin
      e.rej = 1; e.valid = 0;
    end else begin
      m_sum = m_sum + len - m_ring[m_wptr];
      m_ring[m_wptr] = len;
      m_wptr = (m_wptr + 1) % 4;
      if (m_fill < 4) m_fill++;
      if (m_fill == 4) m_full = 1;
      avg  = m_sum / 4;
      m_cm = (avg * 1130) / 65536;
      if (m_cm > 1023) m_cm = 1023;
      e.rej = 0; e.valid = m_full;
    end
    e.cm = m_cm; e.full = m_full;
    exp_q.push_back(e);
  endtask

  // One sample, 4 cycles long so consecutive calls run at full throughput.
  task automatic send(input int len, input string tag);
    exp_t e;
    @(negedge clk50M);
    sample_len  = CAP_LEN'(len);
    sample_done = 1'b1;
    model_push(len);
    @(posedge clk50M); #1;
    nvec++;
    if (dist_valid !== 1'b0 || rejected !== 1'b0) begin
      nerr++; $display("FAIL %s idle strobes: valid=%b rej=%b want 0/0", tag, dist_valid, rejected);
    end
    e = exp_q[0];
    @(posedge clk50M); #1;
    nvec++;
    if (rejected !== e.rej || full !== e.full) begin
      nerr++; $display("FAIL %s accept: rej=%b full=%b want rej=%b full=%b", tag, rejected, full, e.rej, e.full);
    end
    @(posedge clk50M); #1;
    nvec++;
    if (dist_valid !== 1'b0 || rejected !== 1'b0) begin
      nerr++; $display("FAIL %s early: valid=%b rej=%b want 0/0", tag, dist_valid, rejected);
    end
    @(negedge clk50M);
    sample_done = 1'b0;
    @(posedge clk50M); #1;
    e = exp_q.pop_front();
    nvec++;
    if (dist_valid !== e.valid || int'(dist_cm) !== e.cm) begin
      nerr++; $display("FAIL %s out: valid=%b cm=%0d want valid=%b cm=%0d", tag, dist_valid, dist_cm, e.valid, e.cm);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_done = 1'b1; sample_len = 16'd580;
    model_reset();
    repeat (3) @(posedge clk50M);
    @(negedge clk50M); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk50M); #1;
      nvec++;
      if (dist_cm !== '0 || dist_valid !== 1'b0 || full !== 1'b0 || rejected !== 1'b0 ||
          dut.state_q !== 2'd0) begin
        nerr++; $display("FAIL reset cyc%0d: cm=%0d v=%b f=%b r=%b st=%0d want all 0", i,
                         dist_cm, dist_valid, full, rejected, dut.state_q);
      end
    end
    @(negedge clk50M); sample_done = 1'b0;
    repeat (2) @(posedge clk50M);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) send(580, $sformatf("fill%0d", i));
    nvec++;
    if (dist_cm !== 10'd10) begin
      nerr++; $display("FAIL fill_cm: got %0d want 10", dist_cm);
    end
    @(posedge clk50M); #1;
    nvec++;
    if (dist_valid !== 1'b0) begin
      nerr++; $display("FAIL fill_strobe_width: valid=%b want 0", dist_valid);
    end
  endtask

  task automatic test_slide();
    send(5800, "slide0");
    send(5800, "slide1");
    nvec++;
    if (dist_cm !== 10'd55) begin
      nerr++; $display("FAIL slide_half: got %0d want 55", dist_cm);
    end
    send(5800, "slide2");
    send(5800, "slide3");
    nvec++;
    if (dist_cm !== 10'd100) begin
      nerr++; $display("FAIL slide_full: got %0d want 100", dist_cm);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send(65535, $sformatf("sat%0d", i));
    nvec++;
    if (dist_cm !== 10'd1023) begin
      nerr++; $display("FAIL saturate: got %0d want 1023", dist_cm);
    end
  endtask

  task automatic test_outlier();
    for (int i = 0; i < 4; i++) send(580, $sformatf("ofill%0d", i));
    send(0, "out_zero");
    send(30000, "out_big");
    nvec++;
`ifdef RANGE_OUTLIER_REJECT_EN
    if (dist_cm !== 10'd10) begin
      nerr++; $display("FAIL outlier_hold: got %0d want 10", dist_cm);
    end
`else
    if (dist_cm !== 10'd134) begin
      nerr++; $display("FAIL outlier_pass: got %0d want 134", dist_cm);
    end
`endif
    repeat (2) @(posedge clk50M);
  endtask

  task automatic test_mid_reset();
    send(1000, "pre");
    @(negedge clk50M);
    sample_len = 16'd2000; sample_done = 1'b1;
    @(posedge clk50M);
    @(posedge clk50M); #1;
    nvec++;
    if (dut.state_q !== 2'd2) begin
      nerr++; $display("FAIL mid_state: got %0d want 2", dut.state_q);
    end
    rst_n = 1'b0; #1;
    nvec++;
    if (full !== 1'b0 || dist_cm !== '0 || dist_valid !== 1'b0 || dut.state_q !== 2'd0) begin
      nerr++; $display("FAIL mid_reset: f=%b cm=%0d v=%b st=%0d want 0", full, dist_cm, dist_valid, dut.state_q);
    end
    @(negedge clk50M); sample_done = 1'b0;
    @(negedge clk50M); rst_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk50M);
    for (int i = 0; i < 4; i++) send(5800, $sformatf("post%0d", i));
    nvec++;
    if (full !== 1'b1 || dist_cm !== 10'd100) begin
      nerr++; $display("FAIL post_reset: f=%b cm=%0d want 1/100", full, dist_cm);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_slide();
    test_back_to_back();
    test_outlier();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

endmodule
